// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Build option: define DMEM_MISALIGN_ERR_EN to flag misaligned accesses as errors.
package dmem_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Number of word-index bits for an array of the given depth.
  function automatic int index_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 64-bit word array with registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = index_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // NOTE: storage arrays carry no reset; clearing them would cost a full write
  // sweep and the contents are defined only by stores.
  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled edge: either a write or a registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[index] <= wdata;
      else    rdata      <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory responder with LATENCY wait states.
// Build option: DMEM_MISALIGN_ERR_EN makes addr[2:0] != 0 an access error;
// without it the low address bits are ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int         IDX_W = index_w(DEPTH);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_e              state;
  logic [3:0]          cnt;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                rd_sel;

  logic                accept;
  logic                access_now;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                oor;
  logic                acc_err;
  logic                arr_en;
  logic [DATA_W-1:0]   arr_rdata;

  assign accept = req_valid & req_ready;

  // Access on the accept edge when there are no wait states, else when the
  // wait counter reaches its last cycle.
  assign access_now = ((state == IDLE) && accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  // Live request fields feed a zero-latency access; latched ones feed the rest.
  // NOTE: every branch assigns every output, so no latch is inferred.
  always_comb begin
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  assign oor = |acc_addr[ADDR_W-1:IDX_W+3];

`ifdef DMEM_MISALIGN_ERR_EN
  assign acc_err = (|acc_addr[2:0]) | oor;
`else
  logic unused_low_addr;
  assign unused_low_addr = ^acc_addr[2:0];
  assign acc_err = oor;
`endif

  // Faulting accesses and accesses coinciding with reset never reach the array.
  assign arr_en = access_now & ~acc_err & ~reset;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (acc_write),
    .index (acc_addr[IDX_W+2:3]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // Load data shows through only for a successful load; the array output
  // register stays put until the next access, so it is stable during RESP.
  assign resp_rdata = rd_sel ? arr_rdata : '0;

  // Control FSM with registered handshake and response flags.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rd_sel     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= LAT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
              rd_sel     <= ~acc_err & ~req_write;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            rd_sel     <= ~acc_err & ~lat_write;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_sel     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with LATENCY=2 and one
// with LATENCY=0, both DEPTH=256, checked against a word-array reference model.
// Honours DMEM_MISALIGN_ERR_EN the same way the design does.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  logic [63:0] model [2][DEPTH];
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Error rule from the address alone: beyond the array, or misaligned if enabled.
  function automatic logic exp_err(input logic [63:0] a);
`ifdef DMEM_MISALIGN_ERR_EN
    if (a % 8 != 0) return 1'b1;
`endif
    return (a >= 64'(DEPTH * 8));
  endfunction

  task automatic check_reset_state(input int sel, input string tag);
    check({tag, ".req_ready"},  64'(req_ready[sel]),  64'd1);
    check({tag, ".resp_valid"}, 64'(resp_valid[sel]), 64'd0);
    check({tag, ".resp_rdata"}, resp_rdata[sel],      64'd0);
    check({tag, ".resp_err"},   64'(resp_err[sel]),   64'd0);
    check({tag, ".busy"},       64'(busy[sel]),       64'd0);
  endtask

  // One complete transaction; entered and left at a falling edge.
  task automatic txn(input int sel, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input int hold);
    int          lat;
    logic        e;
    logic [63:0] exp_rd;
    lat    = (sel == 0) ? 2 : 0;
    e      = exp_err(addr);
    exp_rd = (wr || e) ? 64'd0 : model[sel][addr / 8];
    if (wr && !e) model[sel][addr / 8] = wdata;

    req_write[sel] = wr;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    req_valid[sel] = 1'b1;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    req_write[sel] = 1'($urandom);
    req_addr[sel]  = {$urandom, $urandom};
    req_wdata[sel] = {$urandom, $urandom};
    for (int k = 0; k < lat; k++) begin
      check("wait.resp_valid", 64'(resp_valid[sel]), 64'd0);
      check("wait.req_ready",  64'(req_ready[sel]),  64'd0);
      check("wait.busy",       64'(busy[sel]),       64'd1);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      check("resp.resp_valid", 64'(resp_valid[sel]), 64'd1);
      check("resp.resp_rdata", resp_rdata[sel],      exp_rd);
      check("resp.resp_err",   64'(resp_err[sel]),   64'(e));
      check("resp.req_ready",  64'(req_ready[sel]),  64'd0);
      if (h < hold) @(negedge clk);
    end
    resp_ready[sel] = 1'b1;
    @(negedge clk);
    resp_ready[sel] = 1'b0;
    check("done.resp_valid", 64'(resp_valid[sel]), 64'd0);
    check("done.req_ready",  64'(req_ready[sel]),  64'd1);
    check("done.busy",       64'(busy[sel]),       64'd0);
  endtask

  // Bound the whole run in case the design wedges the sequence.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [63:0] addr;
    int          r;

    for (int s = 0; s < 2; s++) begin
      reset[s]      = 1'b1;
      req_valid[s]  = 1'b0;
      req_write[s]  = 1'b0;
      req_addr[s]   = '0;
      req_wdata[s]  = '0;
      resp_ready[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset1");
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);

    // Give every word of the LATENCY=2 array a known value.
    for (int i = 0; i < DEPTH; i++) txn(0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 0);

    // Store then load back a fixed pattern.
    txn(0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0);
    txn(0, 1'b0, 64'h10, 64'd0, 0);

    // Response held across five stalled cycles.
    txn(0, 1'b0, 64'h18, 64'd0, 5);

    // Out-of-range load and store; the store must not alias onto word 0.
    txn(0, 1'b0, 64'h800, 64'd0, 1);
    txn(0, 1'b1, 64'h800, 64'h1234_5678_9ABC_DEF0, 0);
    txn(0, 1'b0, 64'h000, 64'd0, 0);

    // Reset on the access edge of a store aborts the write.
    txn(0, 1'b1, 64'h20, 64'h1, 0);
    req_write[0] = 1'b1;
    req_addr[0]  = 64'h20;
    req_wdata[0] = 64'hFFFF_0000_FFFF_0000;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("abort.busy", 64'(busy[0]), 64'd1);
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    check_reset_state(0, "abort");
    reset[0] = 1'b0;
    txn(0, 1'b0, 64'h20, 64'd0, 0);

    // Misaligned store: error or aligned write depending on the build.
    txn(0, 1'b1, 64'h13, {$urandom, $urandom}, 0);
    txn(0, 1'b0, 64'h10, 64'd0, 0);

    // Randomised mix of loads, stores, stalls, bad and misaligned addresses.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        addr = {$urandom, $urandom} | (64'd1 << $urandom_range(11, 63));
      end else begin
        addr = 64'($urandom_range(0, DEPTH - 1)) * 8;
        if (r == 2) addr = addr + 64'($urandom_range(1, 7));
      end
      wr = 1'($urandom);
      txn(0, wr, addr, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    // LATENCY=0 instance: preload, then back-to-back loads with resp_ready high.
    for (int i = 0; i < 4; i++) txn(1, 1'b1, 64'(i * 8), {$urandom, $urandom}, 0);
    resp_ready[1] = 1'b1;
    req_write[1]  = 1'b0;
    req_valid[1]  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[1] = 64'((3 - i) * 8);
      @(negedge clk);
      check("b2b.resp_valid", 64'(resp_valid[1]), 64'd1);
      check("b2b.resp_rdata", resp_rdata[1],      model[1][3 - i]);
      check("b2b.req_ready",  64'(req_ready[1]),  64'd0);
      if (i == 3) req_valid[1] = 1'b0;
      @(negedge clk);
      check("b2b.idle_valid", 64'(resp_valid[1]), 64'd0);
      check("b2b.idle_ready", 64'(req_ready[1]),  64'd1);
    end
    resp_ready[1] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's data-memory load/store port.
- Replaces the zero-wait, combinational-read data memory with a request/response handshake and a parameterised number of wait states.
- The CPU (or a later pipeline MEM stage) issues one request at a time. The block services it from an internal 64-bit word array and returns read data or a write acknowledge.
- Sits between the CPU's ALU-result/store-data outputs and the write-back mux.

Parameters:
- DEPTH, 256, number of 64-bit words in the array (power of two).
- LATENCY, 2, wait-state cycles between request accept and memory access (0..15).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  64  byte address
- req_wdata  input  64  store data
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts response
- resp_rdata  output  64  load data; 0 for stores and errors
- resp_err  output  1  access error flag, qualified by resp_valid
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset
  - One clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, wait counter = 0.
  - Array contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - req_ready = 1.
  - Accept on a clock edge with req_valid & req_ready.
  - On accept, latch write, addr and wdata. Load counter with LATENCY.
  - If LATENCY = 0, perform the access on the accept edge and go to RESP. Otherwise go to WAIT.
- WAIT
  - req_ready = 0. Counter decrements each cycle.
  - On the edge where counter = 1, perform the access and go to RESP.
- Access semantics
  - word index = addr[log2(DEPTH)+2 : 3].
  - Out of range means any addr bit above log2(DEPTH)+2 is set. Then: resp_err = 1, no write, rdata = 0.
  - Store: array[index] <= wdata; rdata = 0.
  - Load: rdata <= array[index], registered.
- RESP
  - resp_valid = 1. resp_rdata and resp_err are held stable until resp_ready.
  - On the edge with resp_ready = 1, go to IDLE and drop resp_valid.
  - A new request cannot be accepted in the same cycle; req_ready is 0 in RESP.
- Latency
  - Accept at edge N gives resp_valid high from edge N+LATENCY+1.
  - With resp_ready tied high, throughput is one request per LATENCY+2 cycles.
- Requester obligations
  - Request fields must be stable while req_valid is high and not yet accepted.
  - req_valid may drop before accept. Fields are ignored when not accepted.
- Reset mid-operation
  - In WAIT: the access is aborted. No write occurs.
  - In RESP: the pending response is discarded. A write already performed remains in the array.
- Simultaneous events: reset has priority over every transition.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - addr[2:0] != 0 is an error: resp_err = 1, no write, rdata = 0.
  - Same timing as a normal access.
  - Misalignment is checked before the range check. Either check sets resp_err.
- Undefined:
  - addr[2:0] is ignored. The access uses the aligned word.
  - Only the out-of-range condition sets resp_err.

Decomposition:
- Shared package dmem_pkg:
  - DATA_W = 64, ADDR_W = 64.
  - State enum {IDLE, WAIT, RESP}.
  - Localparam helper for index width, clog2(DEPTH).
- Sub-module dmem_array:
  - Single-port synchronous array, DEPTH x 64.
  - Ports: clk, en, we, index, wdata, rdata.
  - Registered read; write-first is not required.
- dmem_responder holds the FSM, counter, error checks and response registers.

Test Plan:
1. LATENCY=2, DEPTH=256. Store addr 0x10, wdata 0xDEADBEEF_CAFEF00D, accepted at edge 0 -> resp_valid at edge 3, resp_err=0, rdata=0. Load 0x10 -> rdata 0xDEADBEEF_CAFEF00D.
2. resp_ready held low for 5 cycles during a load of 0x18 -> resp_valid, rdata and err held stable; req_ready=0 throughout; return to IDLE one edge after resp_ready=1.
3. Load addr 0x800 (index 256, out of range) -> resp_err=1, rdata=0. Store to 0x800 -> err=1 and array unchanged; verify by reading 0x000.
4. Assert reset in WAIT of a store to 0x20 (prior content 0x1) -> outputs at reset values next edge; subsequent load of 0x20 returns 0x1.
5. LATENCY=0, back-to-back loads with resp_ready=1 -> resp_valid one edge after each accept; one request per 2 cycles.
6. Misaligned store to addr 0x13:
   - With DMEM_MISALIGN_ERR_EN: resp_err=1, word 0x10 unchanged.
   - Without it: resp_err=0, word 0x10 written.
